// File: rtl/fc_neuron_mac_if.sv
// Activation stream, result stream and configuration bus of one fully-connected neuron.
// The neuron itself sits on the slave side; the driver of activations and weights sits on the master side.
interface fc_neuron_mac_if #(
    parameter int DATA_W = 32,
    parameter int W_W    = 16,
    parameter int OUT_W  = 16,
    parameter int AW     = 4
) ();
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [W_W-1:0]    cfg_wdata;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fc_neuron_mac.sv
// Time-multiplexed fully-connected neuron: one shared signed multiplier accumulates N_IN activations
// against runtime-writable weights, then adds the bias, rescales, optionally applies ReLU and saturates.
module fc_neuron_mac #(
    parameter int N_IN   = 15,
    parameter int DATA_W = 32,
    parameter int W_W    = 16,
    parameter int ACC_W  = 48,
    parameter int FRAC   = 13,
    parameter int OUT_W  = 16,
    parameter int RELU   = 1
) (
    input  logic           clk,
    input  logic           reset,
    fc_neuron_mac_if.slave bus,
    output logic           busy
);
    localparam int AW  = $clog2(N_IN + 1);
    localparam int IW  = $clog2(N_IN);
    localparam int P_W = DATA_W + W_W;

    localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]        O_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        O_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic signed [W_W-1:0]    w_mem_r [N_IN];
    logic signed [W_W-1:0]    bias_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  sum_r;
    logic [IW-1:0]            idx_r;
    logic [OUT_W-1:0]         out_data_r;
    logic                     out_sat_r;
    logic                     out_valid_r;
    logic                     in_ready_r;
    logic                     accept_s;
    logic                     last_s;
    logic                     cfg_ok_s;
    logic signed [P_W-1:0]    prod_s;

    // Returns {sat, data}: floor-shift by FRAC, then ReLU and clip to the signed output range.
    function automatic logic [OUT_W:0] rescale_f(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] q;
        q = s >>> FRAC;
        if ((RELU != 0) && s[ACC_W-1]) begin
            rescale_f = {1'b0, {OUT_W{1'b0}}};
        end else if (q > Q_MAX) begin
            rescale_f = {1'b1, O_MAX};
        end else if ((RELU == 0) && (q < Q_MIN)) begin
            rescale_f = {1'b1, O_MIN};
        end else begin
            rescale_f = {1'b0, q[OUT_W-1:0]};
        end
    endfunction

    assign accept_s = bus.in_valid && in_ready_r;
    assign last_s   = (idx_r == IW'(N_IN - 1));
    // Weights may only change between vectors, so a vector always sees a consistent weight set.
    assign cfg_ok_s = bus.cfg_we && (state_r == IDLE) && (idx_r == {IW{1'b0}});
    assign prod_s   = P_W'($signed(bus.in_data)) * P_W'(w_mem_r[idx_r]);

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;
    assign busy          = (state_r != IDLE);

    // Next-state decode of the accumulate / finish / output sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = ACC;
                else          state_s = IDLE;
            end
            ACC: begin
                if (accept_s && last_s) state_s = FIN;
                else                    state_s = ACC;
            end
            FIN: state_s = OUT;
            OUT: begin
                if (out_valid_r && bus.out_ready) state_s = IDLE;
                else                              state_s = OUT;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Configuration registers, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) w_mem_r[i] <= {W_W{1'b0}};
            bias_r      <= {W_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            sum_r       <= {ACC_W{1'b0}};
            idx_r       <= {IW{1'b0}};
            out_data_r  <= {OUT_W{1'b0}};
            out_sat_r   <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            if (cfg_ok_s) begin
                if (bus.cfg_addr < AW'(N_IN)) begin
                    w_mem_r[bus.cfg_addr[IW-1:0]] <= $signed(bus.cfg_wdata);
                end else if (bus.cfg_addr == AW'(N_IN)) begin
                    bias_r <= $signed(bus.cfg_wdata);
                end
            end

            in_ready_r <= (state_s == IDLE) || (state_s == ACC);

            // A write landing with the first beat does not affect that beat: the read above uses the old W[0].
            if (accept_s) begin
                acc_r <= acc_r + ACC_W'(prod_s);
                idx_r <= last_s ? {IW{1'b0}} : idx_r + IW'(1);
            end

            if (state_r == FIN) begin
                sum_r <= acc_r + ACC_W'(bias_r);
            end

            if ((state_r == OUT) && !out_valid_r) begin
                {out_sat_r, out_data_r} <= rescale_f(sum_r);
                out_valid_r             <= 1'b1;
            end else if (out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
                acc_r       <= {ACC_W{1'b0}};
                idx_r       <= {IW{1'b0}};
            end
        end
    end
endmodule

// File: tb/tb_fc_neuron_mac.sv
// Drives a ReLU and a linear neuron in lockstep and compares both against an arithmetic reference model.
module tb_fc_neuron_mac;
    localparam int N_IN = 15;
    localparam int AW   = 4;

    logic clk = 1'b0;
    logic reset;
    logic busy_r, busy_l;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    longint w_m [N_IN];
    longint bias_m;
    longint act [N_IN];

    fc_neuron_mac_if #(.DATA_W(32), .W_W(16), .OUT_W(16), .AW(AW)) ifr ();
    fc_neuron_mac_if #(.DATA_W(32), .W_W(16), .OUT_W(16), .AW(AW)) ifl ();

    fc_neuron_mac #(.N_IN(N_IN), .RELU(1)) u_relu (.clk(clk), .reset(reset), .bus(ifr), .busy(busy_r));
    fc_neuron_mac #(.N_IN(N_IN), .RELU(0)) u_lin  (.clk(clk), .reset(reset), .bus(ifl), .busy(busy_l));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] d);
        ifr.in_valid = v; ifl.in_valid = v;
        ifr.in_data  = d; ifl.in_data  = d;
    endtask

    task automatic set_cfg(input logic we, input logic [AW-1:0] a, input logic [15:0] d);
        ifr.cfg_we = we; ifl.cfg_we = we;
        ifr.cfg_addr = a; ifl.cfg_addr = a;
        ifr.cfg_wdata = d; ifl.cfg_wdata = d;
    endtask

    task automatic set_ready(input logic r);
        ifr.out_ready = r; ifl.out_ready = r;
    endtask

    function automatic void model_write(input int a, input longint d);
        if (a < N_IN) w_m[a] = d;
        else if (a == N_IN) bias_m = d;
    endfunction

    // Reference result: floor(s / 2^13), then ReLU or two-sided clip to 16-bit signed.
    function automatic void expect_of(input longint s, input bit relu, output longint o, output longint sat);
        longint q;
        q = s >>> 13;
        if (relu && s < 0) begin o = 0; sat = 0; end
        else if (q > 32767) begin o = 32767; sat = 1; end
        else if (!relu && q < -32768) begin o = -32768; sat = 1; end
        else begin o = q; sat = 0; end
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        check_val("rst_out_valid", longint'(ifr.out_valid), 0);
        check_val("rst_in_ready", longint'(ifr.in_ready), 0);
        check_val("rst_out_data", longint'(ifl.out_data), 0);
        check_val("rst_out_sat", longint'(ifl.out_sat), 0);
        check_val("rst_busy", longint'(busy_r | busy_l), 0);
        reset = 1'b0;
        for (int i = 0; i < N_IN; i++) w_m[i] = 0;
        bias_m = 0;
    endtask

    task automatic cfg_write(input int a, input longint d);
        logic [15:0] dv;
        dv = d[15:0];
        @(negedge clk);
        set_cfg(1'b1, AW'(a), dv);
        @(negedge clk);
        set_cfg(1'b0, '0, '0);
        model_write(a, d);
    endtask

    // Sends n beats of act[]; an optional config write rides along with beat cfg_beat.
    task automatic send_vec(input int n, input int gap_max, input int cfg_beat,
                            input int cfg_a, input longint cfg_d, output longint s_exp);
        int t;
        logic [31:0] dv;
        logic [15:0] cv;
        s_exp = act[0] * w_m[0];
        if (cfg_beat == 0) model_write(cfg_a, cfg_d);
        for (int i = 1; i < N_IN; i++) s_exp += act[i] * w_m[i];
        s_exp += bias_m;
        cv = cfg_d[15:0];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gap_max > 0) begin
                set_in(1'b0, '0);
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            end
            dv = act[i][31:0];
            set_in(1'b1, dv);
            if (i == cfg_beat) set_cfg(1'b1, AW'(cfg_a), cv);
            t = 0;
            while (!ifr.in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                check_val("in_ready_timeout", 0, 1);
                set_in(1'b0, '0);
                set_cfg(1'b0, '0, '0);
                return;
            end
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            set_in(1'b0, '0);
            set_cfg(1'b0, '0, '0);
        end
    endtask

    task automatic get_result(input longint s, input int hold, input bit chk_lat, input string tag);
        longint er, sr, el, sl;
        int t;
        expect_of(s, 1'b1, er, sr);
        expect_of(s, 1'b0, el, sl);
        t = 0;
        @(negedge clk);
        while (!ifr.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check_val({tag, "_valid_timeout"}, 0, 1);
            return;
        end
        if (chk_lat) check_val({tag, "_latency"}, longint'(cyc - acc_cyc), 2);
        check_val({tag, "_relu_data"}, longint'($signed(ifr.out_data)), er);
        check_val({tag, "_relu_sat"}, longint'(ifr.out_sat), sr);
        check_val({tag, "_lin_valid"}, longint'(ifl.out_valid), 1);
        check_val({tag, "_lin_data"}, longint'($signed(ifl.out_data)), el);
        check_val({tag, "_lin_sat"}, longint'(ifl.out_sat), sl);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_val({tag, "_hold_valid"}, longint'(ifr.out_valid), 1);
            check_val({tag, "_hold_data"}, longint'($signed(ifl.out_data)), el);
            check_val({tag, "_hold_in_ready"}, longint'(ifr.in_ready | ifl.in_ready), 0);
        end
        set_ready(1'b1);
        @(posedge clk);
        #1;
        set_ready(1'b0);
        @(negedge clk);
        check_val({tag, "_post_valid"}, longint'(ifr.out_valid | ifl.out_valid), 0);
        check_val({tag, "_post_data"}, longint'($signed(ifr.out_data)), er);
    endtask

    task automatic ramp_acts();
        for (int i = 0; i < N_IN; i++) act[i] = i + 1;
    endtask

    task automatic all_weights(input longint w);
        for (int i = 0; i < N_IN; i++) cfg_write(i, w);
        cfg_write(N_IN, 0);
    endtask

    initial begin
        longint s;
        bit big;
        reset = 1'b1;
        set_in(1'b0, '0);
        set_cfg(1'b0, '0, '0);
        set_ready(1'b0);
        do_reset(3);

        // Unit weights (8192 = 1.0 in Q13) over the ramp 1..15
        all_weights(8192);
        ramp_acts();
        send_vec(N_IN, 0, -1, 0, 0, s);
        get_result(s, 0, 1'b1, "c1");

        // Single negative weight: ReLU clamps, linear passes -5
        all_weights(0);
        cfg_write(0, -8192);
        for (int i = 0; i < N_IN; i++) act[i] = longint'($urandom_range(1000, 0)) - 500;
        act[0] = 5;
        send_vec(N_IN, 0, -1, 0, 0, s);
        check_val("c2_model", s, -40960);
        get_result(s, 0, 1'b0, "c2");

        // Positive and negative saturation
        all_weights(32767);
        for (int i = 0; i < N_IN; i++) act[i] = 1 << 20;
        send_vec(N_IN, 0, -1, 0, 0, s);
        get_result(s, 0, 1'b0, "c3p");
        for (int i = 0; i < N_IN; i++) act[i] = -(1 << 20);
        send_vec(N_IN, 0, -1, 0, 0, s);
        get_result(s, 0, 1'b0, "c3n");

        // Back-pressure held for 5 cycles, then a following vector
        for (int i = 0; i < N_IN; i++) cfg_write(i, longint'($urandom_range(2047, 0)) - 1024);
        for (int i = 0; i < N_IN; i++) act[i] = longint'($urandom_range(8191, 0)) - 4096;
        send_vec(N_IN, 0, -1, 0, 0, s);
        get_result(s, 5, 1'b1, "c4hold");
        for (int i = 0; i < N_IN; i++) act[i] = longint'($urandom_range(8191, 0)) - 4096;
        send_vec(N_IN, 1, -1, 0, 0, s);
        get_result(s, 0, 1'b0, "c4next");

        // Reset in the middle of a vector discards it along with the weights
        all_weights(8192);
        for (int i = 0; i < N_IN; i++) act[i] = 1000;
        send_vec(7, 0, -1, 0, 0, s);
        do_reset(2);
        repeat (3) @(negedge clk);
        check_val("c5_no_emit", longint'(ifr.out_valid | ifl.out_valid), 0);
        all_weights(8192);
        ramp_acts();
        send_vec(N_IN, 0, -1, 0, 0, s);
        check_val("c5_model", s, 120 * 8192);
        get_result(s, 0, 1'b1, "c5");

        // Config write during ACC is dropped; in IDLE it lands; with the first beat it misses that beat
        send_vec(N_IN, 0, 3, 0, 0, s);
        check_val("c6_model_drop", s, 120 * 8192);
        get_result(s, 0, 1'b0, "c6drop");
        cfg_write(0, 0);
        send_vec(N_IN, 0, -1, 0, 0, s);
        get_result(s, 0, 1'b0, "c6idle");
        send_vec(N_IN, 0, 0, 0, 8192, s);
        check_val("c6_model_first", s, 119 * 8192);
        get_result(s, 0, 1'b0, "c6first");
        send_vec(N_IN, 0, -1, 0, 0, s);
        get_result(s, 0, 1'b0, "c6after");

        // Randomised vectors, weights, bias, gaps and back-pressure
        for (int v = 0; v < 12; v++) begin
            big = ($urandom_range(3, 0) == 0);
            repeat ($urandom_range(3, 1)) begin
                if (big) cfg_write($urandom_range(N_IN, 0), longint'($urandom_range(65535, 0)) - 32768);
                else     cfg_write($urandom_range(N_IN, 0), longint'($urandom_range(2047, 0)) - 1024);
            end
            for (int i = 0; i < N_IN; i++) begin
                if (big) act[i] = longint'($urandom_range(2097151, 0)) - 1048576;
                else     act[i] = longint'($urandom_range(8191, 0)) - 4096;
            end
            send_vec(N_IN, 2, -1, 0, 0, s);
            get_result(s, $urandom_range(2, 0), 1'b0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
